// File: rtl/dcm_supervisor_if.sv
// dcm_supervisor_if: DCM-side status/control and core reset signals of the clock supervisor
interface dcm_supervisor_if;
  logic       dcm_locked;
  logic [7:0] dcm_status;
  logic       dcm_rst;
  logic       sys_rst;
  logic [7:0] relock_cnt;
  logic       fail;
  modport master (
    input  dcm_locked, dcm_status,
    output dcm_rst, sys_rst, relock_cnt, fail
  );
  modport slave (
    output dcm_locked, dcm_status,
    input  dcm_rst, sys_rst, relock_cnt, fail
  );
endinterface

// File: rtl/dcm_supervisor.sv
// dcm_supervisor: sequences DCM reset, waits for stable lock, releases core reset and relocks on loss
module dcm_supervisor #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 2400000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8
) (
  input logic             clk,
  input logic             rst,
  dcm_supervisor_if.master dcm
);
  typedef enum logic [2:0] {RESET_DCM, WAIT_LOCK, SETTLE, RUN, FAILED} state_t;
  localparam logic [23:0] RST_LAST = 24'(RST_CYCLES - 1);
  localparam logic [23:0] TMO_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] SET_LAST = 24'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  MAXR     = 8'(MAX_RETRIES);
  state_t      state, state_n, retry_state;
  logic [23:0] cnt, cnt_n;
  logic [7:0]  retries, retries_n, retries_inc, relock_n;
  logic [1:0]  lock_sy, st1_sy, st2_sy;
  logic        ok;
  logic        unused_status;
  assign unused_status = ^{dcm.dcm_status[7:3], dcm.dcm_status[0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sy <= '0;
      st1_sy  <= '0;
      st2_sy  <= '0;
    end else begin
      lock_sy <= {lock_sy[0], dcm.dcm_locked};
      st1_sy  <= {st1_sy[0], dcm.dcm_status[1]};
      st2_sy  <= {st2_sy[0], dcm.dcm_status[2]};
    end
  end
  // a stopped input or synthesized clock overrides LOCKED
  assign ok          = lock_sy[1] & ~(st1_sy[1] | st2_sy[1]);
  assign retries_inc = retries + 8'd1;
  assign retry_state = (retries_inc == MAXR) ? FAILED : RESET_DCM;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 24'd1;
    retries_n = retries;
    relock_n  = dcm.relock_cnt;
    case (state)
      RESET_DCM: if (cnt == RST_LAST) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
      WAIT_LOCK: if (ok) begin
        state_n = SETTLE;
        cnt_n   = '0;
      end else if (cnt == TMO_LAST) begin
        state_n   = retry_state;
        retries_n = retries_inc;
        cnt_n     = '0;
      end
      SETTLE: if (!ok) begin
        state_n   = retry_state;
        retries_n = retries_inc;
        cnt_n     = '0;
      end else if (cnt == SET_LAST) begin
        state_n   = RUN;
        retries_n = '0;
        cnt_n     = '0;
      end
      RUN: begin
        cnt_n = '0;
        if (!ok) begin
          state_n  = RESET_DCM;
          relock_n = (dcm.relock_cnt == 8'hff) ? dcm.relock_cnt : dcm.relock_cnt + 8'd1;
        end
      end
      FAILED: cnt_n = '0;
      default: begin
        state_n = RESET_DCM;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RESET_DCM;
      cnt            <= '0;
      retries        <= '0;
      dcm.dcm_rst    <= 1'b1;
      dcm.sys_rst    <= 1'b1;
      dcm.relock_cnt <= '0;
      dcm.fail       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      retries        <= retries_n;
      dcm.dcm_rst    <= (state_n == RESET_DCM) || (state_n == FAILED);
      dcm.sys_rst    <= state_n != RUN;
      dcm.relock_cnt <= relock_n;
      dcm.fail       <= state_n == FAILED;
    end
  end
endmodule

// File: doc/dcm_supervisor.md
# dcm_supervisor

Sequences and monitors the Spartan-3 clock synthesizer DCM that produces the core clock. It drives the DCM's asynchronous reset input, samples its LOCKED and STATUS outputs, and holds the system reset until lock is stable. On loss of lock or a stopped clock it forces a relock, and after repeated lock timeouts it declares a hard failure. The block sits in the top level on the 24 MHz input clock domain (the DCM's CLKIN), which never stops.

## Interface
Parameters:
- RST_CYCLES, 4: cycles DCM_RST is held high per reset pulse. Minimum legal value is 3, the DCM requirement.
- LOCK_TIMEOUT, 2400000: cycles to wait for lock before retrying (100 ms at 24 MHz). Counter is 24 bits wide.
- SETTLE_CYCLES, 1024: consecutive cycles of clean lock required before releasing SYS_RST.
- MAX_RETRIES, 8: consecutive failed lock attempts before entering FAILED. Range 1–255.

Ports:
- CLK, in, 1: 24 MHz input clock, same net as DCM CLKIN.
- RST, in, 1: synchronous, active-high reset.
- DCM_LOCKED, in, 1: DCM LOCKED output. Asynchronous to CLK.
- DCM_STATUS, in, 8: DCM STATUS output. Only bit 1 (CLKIN stopped) and bit 2 (CLKFX stopped) are used. Asynchronous.
- DCM_RST, out, 1: drives the DCM RST pin. Registered.
- SYS_RST, out, 1: active-high reset for all core logic. Registered.
- RELOCK_CNT, out, 8: number of lock losses while in RUN. Saturates at 255.
- FAIL, out, 1: high in the FAILED state.

## Operation
- Synchronizers: DCM_LOCKED, DCM_STATUS[1] and DCM_STATUS[2] each pass through a two-flop synchronizer.
  - Synchronized signals: lock_s = synchronized LOCKED; bad_s = synchronized STATUS[1] OR synchronized STATUS[2].
  - Synchronizer flops reset to 0.
- One 24-bit cycle counter (cnt) and one 8-bit retry counter (retries) are shared across states.
- States:
  - RESET_DCM: DCM_RST=1, SYS_RST=1. cnt increments each cycle. When cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt<=0.
  - WAIT_LOCK: DCM_RST=0, SYS_RST=1.
    - lock_s=1 and bad_s=0: go to SETTLE, cnt<=0.
    - Else, if cnt==LOCK_TIMEOUT-1: retries<=retries+1. If retries+1==MAX_RETRIES go to FAILED, else go to RESET_DCM. cnt<=0 in both cases.
    - Else cnt increments.
  - SETTLE: DCM_RST=0, SYS_RST=1.
    - lock_s=0 or bad_s=1: counts as a failed attempt. Same retry/FAILED logic as a timeout; next state RESET_DCM or FAILED.
    - Else, if cnt==SETTLE_CYCLES-1: go to RUN, retries<=0.
    - Else cnt increments.
  - RUN: DCM_RST=0, SYS_RST=0.
    - lock_s=0 or bad_s=1: go to RESET_DCM, cnt<=0, RELOCK_CNT increments (saturating). retries is unchanged (0).
  - FAILED: DCM_RST=1, SYS_RST=1, FAIL=1. Terminal; exits only on RST.
- DCM_RST, SYS_RST and FAIL are registered from the next state. They change on the same edge as the state register.
- Arithmetic: all counters are unsigned. RELOCK_CNT does not wrap (255 stays 255). retries never exceeds MAX_RETRIES.

## Timing
- Reset values while RST=1:
  - State RESET_DCM; cnt=0, retries=0.
  - DCM_RST=1, SYS_RST=1, RELOCK_CNT=0, FAIL=0.
- RST mid-operation (any state, including RUN and FAILED): on the next edge, state is RESET_DCM and all reset values apply. RELOCK_CNT clears.
- DCM_RST pulse width: after RST deasserts, DCM_RST stays high for exactly RST_CYCLES edges, then falls.
- Lock latency: DCM_LOCKED sampled high at edge E0 gives lock_s=1 after E1 and state SETTLE after E2. With a clean lock, SYS_RST falls at edge E2+SETTLE_CYCLES.
- Loss latency: DCM_LOCKED sampled low at edge E0 means SYS_RST and DCM_RST are high after E2 (a 2-edge synchronizer plus 1 registered decision; the transition occurs on E2).
- Simultaneous events:
  - Lock detected on the same cycle as the timeout: lock wins.
  - lock_s=1 with bad_s=1: treated as no lock.
- Glitches: a one-cycle low on lock_s in SETTLE aborts settling. The same glitch in RUN forces a relock.

## Test plan
Directed scenarios use RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, MAX_RETRIES=3.

1. Clean bring-up: release RST, raise DCM_LOCKED 10 cycles after DCM_RST falls. Expect:
   - DCM_RST high for exactly 4 cycles.
   - SYS_RST falls 18 edges after the first edge sampling LOCKED high.
   - RELOCK_CNT=0, FAIL=0.
2. Lock timeout/FAILED: keep DCM_LOCKED low. Expect:
   - 3 DCM_RST pulses of 4 cycles, spaced by 100-cycle waits.
   - Then FAIL=1, DCM_RST=1, SYS_RST=1, held for 1000 further cycles.
   - RST then returns to reset values.
3. Relock in RUN: after bring-up, drop DCM_LOCKED for 1 cycle, then restore. Expect:
   - SYS_RST=1 within 2 edges.
   - A 4-cycle DCM_RST pulse.
   - RELOCK_CNT=1.
   - SYS_RST low again after the settle period.
4. Stopped clock: in RUN, assert DCM_STATUS[2] with LOCKED held high. Expect the same relock as scenario 3 and RELOCK_CNT=1. Asserting DCM_STATUS[0] alone has no effect.
5. Settle abort: LOCKED rises, then drops 8 cycles into SETTLE. Expect:
   - retries=1 and a new DCM_RST pulse.
   - SYS_RST never falls.
   - Two more aborts give FAIL=1.
6. Saturation and reset mid-run: force 300 relocks. Expect RELOCK_CNT=255. Assert RST during RUN; expect all outputs at reset values on the next edge.
